i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Synthesizable I2C target (responder), the far end of the I2C master protocol used for ADV7511 bring-up.
- Default address is 0x39, so the block can stand in for the ADV7511 main map.
- Serves two roles: an on-board loopback bus model for checking the init sequencer, and a register port for future control-plane slaves.
- Register storage is external. The block issues write strobes and read requests and holds only an 8-bit register pointer.

Parameters:
SLAVE_ADDR, 7'h39, 7-bit address this target ACKs.
FILTER_LEN, 4, consecutive identical synced samples needed before a filtered SCL/SDA value changes.
HOLD_CYCLES, 30, clk cycles after a filtered SCL falling edge before SDA drive changes (300 ns at 100 MHz).

Ports:
clk  in  1  system clock (clk_100mhz domain).
rst  in  1  synchronous, active-high reset.
scl_i  in  1  raw SCL from IOBUF.
sda_i  in  1  raw SDA from IOBUF.
sda_o  out  1  constant 0 (open-drain).
sda_oe  out  1  1 = pull SDA low.
bus_busy  out  1  START seen, STOP not yet seen.
selected  out  1  address matched in the current transaction.
wr_valid  out  1  one-cycle write strobe.
wr_addr  out  8  register address for the write.
wr_data  out  8  register data for the write.
rd_req  out  1  one-cycle read request.
rd_addr  out  8  register address for the read.
rd_data  in  8  read data; must be valid the cycle after rd_req.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values: sda_oe=0, bus_busy=0, selected=0, wr_valid=0, rd_req=0, wr_addr/wr_data/rd_addr=0, pointer=0, state=IDLE. sda_o=0 always.
- Input conditioning: 2-FF synchronizer on scl_i and sda_i, then FILTER_LEN filter, then 1-cycle edge detect on the filtered values.
- START = filtered SDA falls while filtered SCL is high. STOP = filtered SDA rises while filtered SCL is high.
- Bit timing: bits are sampled on filtered SCL rising edges, MSB first. Any SDA drive change occurs exactly HOLD_CYCLES clk cycles after a filtered SCL falling edge.
- No clock stretching.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state: enter ADDR, bus_busy=1, bit counter cleared, sda_oe=0.
- STOP from any state: enter IDLE, bus_busy=0, selected=0, sda_oe=0 the next cycle.
- START/STOP detection overrides any pending SCL-edge action in the same cycle.
- ADDR, after 8 bits:
  - Address field == SLAVE_ADDR: selected=1, go to ADDR_ACK, latch R/W.
  - Mismatch, including general call 0x00: go to IGNORE, SDA never driven. IGNORE is left only on START or STOP.
- ACK drive: sda_oe asserts HOLD_CYCLES after the SCL fall ending bit 8. It releases HOLD_CYCLES after the SCL fall ending the ACK bit.
- Write path (R/W=0):
  - First byte loads the pointer (REG, REG_ACK).
  - Each later byte (WDATA) is ACKed. At its 8th rising edge, wr_valid pulses for 1 cycle with wr_addr=pointer and wr_data=byte.
  - Pointer then increments mod 256 (0xFF -> 0x00).
  - Every byte is ACKed; no NACK on write.
- Read path (R/W=1):
  - At the 8th address rising edge, rd_req pulses with rd_addr=pointer. rd_data is latched 2 cycles later into the TX shift register.
  - Bits: bit 7 is driven HOLD_CYCLES after the SCL fall ending ADDR_ACK (sda_oe = ~bit). Each following bit is driven HOLD_CYCLES after the next SCL fall.
  - After bit 0's SCL fall + HOLD_CYCLES, SDA is released and the master ACK is sampled at the 9th rising edge.
  - Pointer increments after every transmitted byte.
  - Master ACK: rd_req is reissued for the new pointer and the next byte follows.
  - Master NACK: go to IGNORE; SDA stays released.
- Repeated START: pointer is retained, which supports the write-pointer-then-read sequence. The pointer also persists across STOP.
- Reset mid-transaction: SDA is released the next cycle, the block goes to IDLE, and the bus is ignored until a fresh START.
- START with SCL low is not recognized as a START.

Test Plan:
- Single write: START, 0x72, 0x41, 0x10, STOP -> ACK on all 3 bytes; one wr_valid with wr_addr=0x41, wr_data=0x10; bus_busy 1 then 0.
- Burst write with wrap: START, 0x72, 0xFE, 0xAA, 0xBB, 0xCC, STOP -> wr_valid at (0xFE,0xAA), (0xFF,0xBB), (0x00,0xCC); final pointer 0x01.
- Random read: START, 0x72, 0x96, Sr, 0x73, read 1 byte with NACK, STOP; rd_data=0x5A when rd_addr=0x96 -> rd_req with rd_addr=0x96; master reads 0x5A; next write-less read returns data for 0x97.
- Address mismatch: START, 0x70, 0x41, 0x10, STOP -> sda_oe never 1; no wr_valid; selected stays 0.
- Glitch rejection: 2-cycle SCL high pulse (< FILTER_LEN) inserted mid-byte during a write of 0x10 -> wr_data=0x10, no extra bit counted.
- Reset mid-read while sda_oe=1 -> sda_oe=0 one cycle after rst. A following START, 0x72, 0x00, 0x55, STOP succeeds with wr_addr=0x00.

Source files
------------

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: I2C target (responder) with external register storage.
// Conditions raw SCL/SDA (2-FF sync, glitch filter, edge detect), decodes
// START/STOP, matches SLAVE_ADDR, and turns bus writes into one-cycle write
// strobes and bus reads into one-cycle read requests. Only the 8-bit
// register pointer lives here. No clock stretching.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   scl_i, sda_i          raw bus inputs from the IOBUF
//   sda_o, sda_oe         open-drain drive (sda_o tied 0, sda_oe=1 pulls low)
//   bus_busy, selected    START..STOP window / address matched this transfer
//   wr_valid/addr/data    one-cycle register write strobe
//   rd_req/rd_addr        one-cycle register read request
//   rd_data               read data, valid the cycle after rd_req
// HOLD_CYCLES and FILTER_LEN must both be at least 1.
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h39,
  parameter int         FILTER_LEN  = 4,
  parameter int         HOLD_CYCLES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic       bus_busy,
  output logic       selected,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic          r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic          r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;
  logic [FW-1:0] r_scl_cnt, r_sda_cnt;

  state_t        r_state;
  logic          r_busy, r_sel, r_oe, r_rw, r_ld;
  logic          r_wr_valid, r_rd_req;
  logic [7:0]    r_wr_addr, r_wr_data, r_rd_addr, r_ptr, r_tx;
  logic [6:0]    r_rx;
  logic [2:0]    r_bitcnt;
  logic          r_hold_act, r_pend;
  logic [HW-1:0] r_hold_cnt;

  logic          w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]    w_byte;

  // Synchronizer and filter: the filtered value only follows the synced
  // input after FILTER_LEN consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1;
      r_scl_f  <= 1'b1; r_sda_f  <= 1'b1; r_scl_fd <= 1'b1; r_sda_fd <= 1'b1;
      r_scl_cnt <= '0;  r_sda_cnt <= '0;
    end else begin
      r_scl_s1 <= scl_i;    r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_i;    r_sda_s2 <= r_sda_s1;
      r_scl_fd <= r_scl_f;  r_sda_fd <= r_sda_f;
      if (r_scl_s2 == r_scl_f) r_scl_cnt <= '0;
      else if (r_scl_cnt == FW'(FILTER_LEN - 1)) begin
        r_scl_f   <= r_scl_s2;
        r_scl_cnt <= '0;
      end else r_scl_cnt <= r_scl_cnt + FW'(1);
      if (r_sda_s2 == r_sda_f) r_sda_cnt <= '0;
      else if (r_sda_cnt == FW'(FILTER_LEN - 1)) begin
        r_sda_f   <= r_sda_s2;
        r_sda_cnt <= '0;
      end else r_sda_cnt <= r_sda_cnt + FW'(1);
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_fd;
  assign w_scl_fall = ~r_scl_f & r_scl_fd;
  // SCL must be high both before and after the SDA edge.
  assign w_start    = r_sda_fd & ~r_sda_f & r_scl_f & r_scl_fd;
  assign w_stop     = ~r_sda_fd & r_sda_f & r_scl_f & r_scl_fd;
  assign w_byte     = {r_rx, r_sda_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;  r_busy     <= 1'b0; r_sel      <= 1'b0; r_oe   <= 1'b0;
      r_rw       <= 1'b0;  r_ld       <= 1'b0; r_wr_valid <= 1'b0; r_rd_req <= 1'b0;
      r_wr_addr  <= '0;    r_wr_data  <= '0;   r_rd_addr  <= '0;   r_ptr  <= '0;
      r_tx       <= '0;    r_rx       <= '0;   r_bitcnt   <= '0;
      r_hold_act <= 1'b0;  r_pend     <= 1'b0; r_hold_cnt <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      r_rd_req   <= 1'b0;
      // rd_data is valid the cycle after rd_req; capture it then.
      r_ld       <= r_rd_req;
      if (r_ld) r_tx <= rd_data;

      if (w_start) begin
        r_state    <= ADDR;
        r_busy     <= 1'b1;
        r_sel      <= 1'b0;
        r_bitcnt   <= '0;
        r_oe       <= 1'b0;
        r_hold_act <= 1'b0;
      end else if (w_stop) begin
        r_state    <= IDLE;
        r_busy     <= 1'b0;
        r_sel      <= 1'b0;
        r_oe       <= 1'b0;
        r_hold_act <= 1'b0;
      end else if (r_state != IDLE) begin
        // Deferred SDA drive: the value chosen at an SCL fall is applied
        // HOLD_CYCLES later so it never changes near an SCL edge.
        if (r_hold_act) begin
          if (r_hold_cnt == '0) begin
            r_oe       <= r_pend;
            r_hold_act <= 1'b0;
          end else r_hold_cnt <= r_hold_cnt - HW'(1);
        end

        if (w_scl_fall) begin
          r_hold_act <= 1'b1;
          r_hold_cnt <= HW'(HOLD_CYCLES - 1);
          case (r_state)
            ADDR_ACK, REG_ACK, WDATA_ACK: r_pend <= 1'b1;
            RDATA: begin
              r_pend <= ~r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b1};
            end
            default: r_pend <= 1'b0;
          endcase
        end

        if (w_scl_rise) begin
          r_rx <= w_byte[6:0];
          case (r_state)
            ADDR: begin
              if (r_bitcnt == 3'd7) begin
                r_bitcnt <= '0;
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  r_sel   <= 1'b1;
                  r_rw    <= w_byte[0];
                  r_state <= ADDR_ACK;
                  if (w_byte[0]) begin
                    r_rd_req  <= 1'b1;
                    r_rd_addr <= r_ptr;
                  end
                end else r_state <= IGNORE;
              end else r_bitcnt <= r_bitcnt + 3'd1;
            end
            ADDR_ACK: begin
              r_state  <= r_rw ? RDATA : REG;
              r_bitcnt <= '0;
            end
            REG: begin
              if (r_bitcnt == 3'd7) begin
                r_ptr    <= w_byte;
                r_bitcnt <= '0;
                r_state  <= REG_ACK;
              end else r_bitcnt <= r_bitcnt + 3'd1;
            end
            REG_ACK, WDATA_ACK: begin
              r_state  <= WDATA;
              r_bitcnt <= '0;
            end
            WDATA: begin
              if (r_bitcnt == 3'd7) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_ptr;
                r_wr_data  <= w_byte;
                r_ptr      <= r_ptr + 8'd1;
                r_bitcnt   <= '0;
                r_state    <= WDATA_ACK;
              end else r_bitcnt <= r_bitcnt + 3'd1;
            end
            RDATA: begin
              if (r_bitcnt == 3'd7) begin
                r_ptr    <= r_ptr + 8'd1;
                r_bitcnt <= '0;
                r_state  <= RDATA_ACK;
              end else r_bitcnt <= r_bitcnt + 3'd1;
            end
            RDATA_ACK: begin
              // Master ACK (SDA low) asks for another byte; NACK ends the read.
              if (!r_sda_f) begin
                r_rd_req  <= 1'b1;
                r_rd_addr <= r_ptr;
                r_bitcnt  <= '0;
                r_state   <= RDATA;
              end else r_state <= IGNORE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign sda_o    = 1'b0;
  assign sda_oe   = r_oe;
  assign bus_busy = r_busy;
  assign selected = r_sel;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_req   = r_rd_req;
  assign rd_addr  = r_rd_addr;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Testbench for i2c_target: a bit-banged I2C master drives the bus, a small
// register memory answers read requests, and a monitor pops expected write
// strobes and read requests from queues as the DUT presents them.
module tb_i2c_target;

  localparam int Q = 50;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] rd_data;
  logic       sda_o, sda_oe, bus_busy, selected, wr_valid, rd_req;
  logic [7:0] wr_addr, wr_data, rd_addr;
  wire        sda_line = m_sda & ~sda_oe;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_count = 0;
  int          wr_snap;
  int          wcnt;
  logic        oe_seen = 1'b0;
  logic        sel_seen = 1'b0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] mon_wr;
  logic [7:0]  mon_rd;
  logic [7:0]  mem[256];
  logic [7:0]  rbyte;
  logic        ack;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_line),
    .sda_o(sda_o), .sda_oe(sda_oe), .bus_busy(bus_busy), .selected(selected),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // External register file answering read requests one cycle later.
  always @(posedge clk) if (rd_req) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe)   oe_seen  = 1'b1;
      if (selected) sel_seen = 1'b1;
      if (wr_valid) begin
        wr_count++;
        if (exp_wr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
        end else begin
          mon_wr = exp_wr.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_wr[15:8]));
          check("wr_data", 32'(wr_data), 32'(mon_wr[7:0]));
        end
      end
      if (rd_req) begin
        if (exp_rd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_unexpected: got rd_addr 0x%0h, expected no read", rd_addr);
        end else begin
          mon_rd = exp_rd.pop_front();
          check("rd_addr", 32'(rd_addr), 32'(mon_rd));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); m_sda = 1'b0;
    tick(Q); m_scl = 1'b1;
    tick(Q); m_sda = 1'b1;
    tick(Q);
  endtask

  // glitch >= 0 inserts a 2-cycle SCL high pulse in the low phase of that bit.
  task automatic write_byte(input logic [7:0] b, input int glitch, output logic a);
    for (int i = 7; i >= 0; i--) begin
      tick(Q); m_sda = b[i];
      if (i == glitch) begin
        tick(10); m_scl = 1'b1; tick(2); m_scl = 1'b0; tick(Q - 12);
      end else tick(Q);
      m_scl = 1'b1; tick(2 * Q); m_scl = 1'b0;
    end
    tick(Q); m_sda = 1'b1;
    tick(Q); m_scl = 1'b1;
    tick(Q); a = ~sda_line;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic wr_chk(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    write_byte(b, -1, a);
    check(nm, 32'(a), 32'(exp_ack));
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick(Q); m_sda = 1'b1;
      tick(Q); m_scl = 1'b1;
      tick(Q); b[i] = sda_line;
      tick(Q); m_scl = 1'b0;
    end
    tick(Q); m_sda = ~master_ack;
    tick(Q); m_scl = 1'b1;
    tick(2 * Q); m_scl = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish within 3 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h96] = 8'h5A;

    // Reset state
    tick(5);
    check("rst_sda_oe",   32'(sda_oe),   32'h0);
    check("rst_bus_busy", 32'(bus_busy), 32'h0);
    check("rst_selected", 32'(selected), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_rd_req",   32'(rd_req),   32'h0);
    check("rst_wr_addr",  32'(wr_addr),  32'h0);
    check("rst_wr_data",  32'(wr_data),  32'h0);
    check("rst_rd_addr",  32'(rd_addr),  32'h0);
    check("rst_sda_o",    32'(sda_o),    32'h0);
    rst = 1'b0;
    tick(20);

    // Single write
    exp_wr.push_back({8'h41, 8'h10});
    i2c_start();
    check("t1_busy_after_start", 32'(bus_busy), 32'h1);
    wr_chk(8'h72, 1'b1, "t1_addr_ack");
    check("t1_selected", 32'(selected), 32'h1);
    wr_chk(8'h41, 1'b1, "t1_reg_ack");
    wr_chk(8'h10, 1'b1, "t1_data_ack");
    i2c_stop();
    check("t1_busy_after_stop", 32'(bus_busy), 32'h0);
    check("t1_selected_after_stop", 32'(selected), 32'h0);

    // Burst write with pointer wrap, then read back at the final pointer
    exp_wr.push_back({8'hFE, 8'hAA});
    exp_wr.push_back({8'hFF, 8'hBB});
    exp_wr.push_back({8'h00, 8'hCC});
    i2c_start();
    wr_chk(8'h72, 1'b1, "t2_addr_ack");
    wr_chk(8'hFE, 1'b1, "t2_reg_ack");
    wr_chk(8'hAA, 1'b1, "t2_d0_ack");
    wr_chk(8'hBB, 1'b1, "t2_d1_ack");
    wr_chk(8'hCC, 1'b1, "t2_d2_ack");
    i2c_stop();
    exp_rd.push_back(8'h01);
    i2c_start();
    wr_chk(8'h73, 1'b1, "t2_rd_addr_ack");
    read_byte(1'b0, rbyte);
    check("t2_rd_byte", 32'(rbyte), 32'hA4);
    i2c_stop();

    // Random read: set pointer, repeated START, read with NACK
    exp_rd.push_back(8'h96);
    i2c_start();
    wr_chk(8'h72, 1'b1, "t3_addr_ack");
    wr_chk(8'h96, 1'b1, "t3_reg_ack");
    i2c_start();
    wr_chk(8'h73, 1'b1, "t3_rd_addr_ack");
    read_byte(1'b0, rbyte);
    check("t3_rd_byte", 32'(rbyte), 32'h5A);
    i2c_stop();
    exp_rd.push_back(8'h97);
    i2c_start();
    wr_chk(8'h73, 1'b1, "t3_rd2_addr_ack");
    read_byte(1'b0, rbyte);
    check("t3_rd2_byte", 32'(rbyte), 32'h32);
    i2c_stop();

    // Address mismatch: bus must be ignored entirely
    oe_seen  = 1'b0;
    sel_seen = 1'b0;
    wr_snap  = wr_count;
    i2c_start();
    wr_chk(8'h70, 1'b0, "t4_addr_nack");
    wr_chk(8'h41, 1'b0, "t4_reg_nack");
    wr_chk(8'h10, 1'b0, "t4_data_nack");
    i2c_stop();
    check("t4_oe_never", 32'(oe_seen), 32'h0);
    check("t4_sel_never", 32'(sel_seen), 32'h0);
    check("t4_no_write", 32'(wr_count), 32'(wr_snap));

    // Glitch rejection: short SCL pulse inside a data bit
    exp_wr.push_back({8'h20, 8'h10});
    i2c_start();
    wr_chk(8'h72, 1'b1, "t5_addr_ack");
    wr_chk(8'h20, 1'b1, "t5_reg_ack");
    write_byte(8'h10, 3, ack);
    check("t5_data_ack", 32'(ack), 32'h1);
    i2c_stop();

    // Reset while the target drives SDA during a read
    exp_rd.push_back(8'h96);
    i2c_start();
    wr_chk(8'h72, 1'b1, "t6_addr_ack");
    wr_chk(8'h96, 1'b1, "t6_reg_ack");
    i2c_start();
    wr_chk(8'h73, 1'b1, "t6_rd_addr_ack");
    wcnt = 0;
    while (!sda_oe && wcnt < 200) begin
      tick(1);
      wcnt++;
    end
    check("t6_oe_before_rst", 32'(sda_oe), 32'h1);
    rst = 1'b1;
    tick(1);
    check("t6_oe_after_rst", 32'(sda_oe), 32'h0);
    check("t6_busy_after_rst", 32'(bus_busy), 32'h0);
    check("t6_sel_after_rst", 32'(selected), 32'h0);
    rst = 1'b0;
    m_sda = 1'b1;
    tick(Q); m_scl = 1'b1;
    tick(2 * Q);
    exp_wr.push_back({8'h00, 8'h55});
    i2c_start();
    wr_chk(8'h72, 1'b1, "t6_w_addr_ack");
    wr_chk(8'h00, 1'b1, "t6_w_reg_ack");
    wr_chk(8'h55, 1'b1, "t6_w_data_ack");
    i2c_stop();

    tick(10);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'h0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
